multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Control sequencer for a multi-cycle variant of the MIPS datapath. It replaces the single-cycle decoder with a Moore FSM plus a small Mealy gating path.
- Each instruction is spread over 3-5 states that share one ALU and one unified instruction/data memory.
- The memory port uses a req/ready handshake, so the FSM stalls on wait states.
- Instruction subset: lw, sw, R-type (add, sub, and, or, slt), addi, beq, j. Anything else raises illegal_op.

Parameters:
- OPW, 6, opcode and funct field width.
- ALUCW, 3, ALU control width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- opcode  in  6  instr[31:26] from the instruction register; stable after IRWrite
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag, used in the BRANCH state
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- IorD  out  1  0 = PC address, 1 = ALUOut address
- MemWrite  out  1  write strobe, qualified by mem_req
- IRWrite  out  1  load the instruction register
- RegDst  out  1  1 = rd, 0 = rt
- MemtoReg  out  1  1 = MDR, 0 = ALUOut
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2
- ALUcontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC write = PCWrite | (Branch & zero)
- illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct
- busy_state  out  4  current state code, for debug and bench

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Reset: on the rising edge with rst=1, state <= FETCH.
  - While rst=1, mem_req, MemWrite, IRWrite, RegWrite, PCEn and illegal_op are forced to 0.
  - All other outputs take their FETCH values.
  - Reset mid-access abandons the access and asserts no write.
- FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUcontrol=010, PCSrc=00.
  - IRWrite=PCEn=mem_ready (Mealy).
  - Stay in FETCH while mem_ready=0; go to DECODE on mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut). Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 with a legal funct -> EXEC
  - 001000 -> ADDIEX
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - otherwise illegal_op=1 -> FETCH. Legal funct values: 100000, 100010, 100100, 100101, 101010. PC has already been incremented.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. opcode 100011 -> MEMRD; 101011 -> MEMWR.
- MEMRD: mem_req=1, IorD=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1, then FETCH.
- MEMWR: mem_req=1, IorD=1, MemWrite=1. Hold until mem_ready=1, then FETCH. MemWrite stays high throughout the wait.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUcontrol from funct, then ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, then FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add, then ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, Branch=1, PCSrc=01. PCEn=zero. Then FETCH.
- JUMP: PCSrc=10, PCEn=1, then FETCH.
- Signals not listed for a state are 0. ALUcontrol defaults to 010.
- Latency with zero wait states, in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each wait cycle adds 1 in FETCH, MEMRD or MEMWR.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- An unreachable state code returns to FETCH on the next edge, with no strobes asserted.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J
  - funct constants
  - ALU control codes ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  - the state encoding
- One sub-module, alu_decoder: purely combinational. Inputs are a 2-bit ALUOp (00 add, 01 sub, 10 use funct) and funct. Outputs are ALUcontrol and funct_legal. The FSM instantiates it once.

Test Plan:
- lw (opcode 100011), mem_ready=1 always -> states 0,1,2,3,4,0. IRWrite high in cycle 0. RegWrite=1 and MemtoReg=1 in cycle 4 only.
- sw (101011), mem_ready low for 2 cycles in MEMWR -> MemWrite=1 and mem_req=1 for 3 cycles, IorD=1, RegWrite never asserted.
- R-type (000000), funct 100010 then 101010 -> ALUcontrol=110 then 111 in EXEC. In ALUWB, RegDst=1 and RegWrite=1.
- beq (000100), run twice -> zero=1 gives PCEn=1 with PCSrc=01 in BRANCH; zero=0 gives PCEn=0 there. Both return to FETCH after 3 cycles.
- Illegal encodings, each run separately -> illegal_op pulses exactly 1 cycle in DECODE and state returns to 0, with no RegWrite or MemWrite.
  - opcode 011010
  - opcode 000000 with funct 011100
  - opcode 000111
- j (000010) gives PCSrc=10 and PCEn=1 in JUMP. Separately, assert rst during MEMRD with mem_ready=0 -> state 0 next cycle and all strobes 0 while rst=1.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared constants for the multi-cycle MIPS control path: opcodes, functs,
// ALU control codes and the externally visible state encoding.
package mips_ctrl_pkg;

  localparam int unsigned OPW   = 6;
  localparam int unsigned ALUCW = 3;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;

  localparam logic [OPW-1:0] FN_ADD = 6'b100000;
  localparam logic [OPW-1:0] FN_SUB = 6'b100010;
  localparam logic [OPW-1:0] FN_AND = 6'b100100;
  localparam logic [OPW-1:0] FN_OR  = 6'b100101;
  localparam logic [OPW-1:0] FN_SLT = 6'b101010;

  localparam logic [ALUCW-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUCW-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUCW-1:0] ALU_AND = 3'b000;
  localparam logic [ALUCW-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUCW-1:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } alu_op_e;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the sequencer and the datapath/memory.
interface multicycle_control_fsm_if;
  import mips_ctrl_pkg::*;

  logic [OPW-1:0]   opcode;
  logic [OPW-1:0]   funct;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             IorD;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [ALUCW-1:0] ALUcontrol;
  logic [1:0]       PCSrc;
  logic             PCEn;
  logic             illegal_op;
  logic [3:0]       busy_state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUcontrol, PCSrc, PCEn, illegal_op, busy_state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUcontrol, PCSrc, PCEn, illegal_op, busy_state
  );

endinterface

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp/funct to an ALU control code and
// reports whether funct is one of the supported R-type operations.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_op_e          alu_op_i,
  input  logic [OPW-1:0]   funct_i,
  output logic [ALUCW-1:0] alu_control_o,
  output logic             funct_legal_o
);

  logic [ALUCW-1:0] funct_ctrl;

  // funct_legal_o is independent of alu_op_i so DECODE can screen R-types.
  always_comb begin
    funct_legal_o = 1'b1;
    funct_ctrl    = ALU_ADD;
    case (funct_i)
      FN_ADD:  funct_ctrl = ALU_ADD;
      FN_SUB:  funct_ctrl = ALU_SUB;
      FN_AND:  funct_ctrl = ALU_AND;
      FN_OR:   funct_ctrl = ALU_OR;
      FN_SLT:  funct_ctrl = ALU_SLT;
      default: funct_legal_o = 1'b0;
    endcase
  end

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      AluOpSub:   alu_control_o = ALU_SUB;
      AluOpFunct: alu_control_o = funct_ctrl;
      default:    alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: Moore state outputs plus Mealy gating of
// IRWrite/PCEn on mem_ready and of PCEn on zero.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  multicycle_control_fsm_if.master bus
);

  state_e state_q, state_d;
  alu_op_e alu_op;
  logic [ALUCW-1:0] alu_control;
  logic funct_legal;

  logic mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic alu_src_a, pc_write, branch, illegal_op;
  logic [1:0] alu_src_b, pc_src;

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct_i       (bus.funct),
    .alu_control_o (alu_control),
    .funct_legal_o (funct_legal)
  );

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = AluOpAdd;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = StDecode;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        state_d   = StFetch;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_ADDI:      state_d = StAddiEx;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
          OP_RTYPE: begin
            if (funct_legal) state_d = StExec;
            else             illegal_op = 1'b1;
          end
          default:      illegal_op = 1'b1;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == OP_SW) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (bus.mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) state_d = StFetch;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = AluOpFunct;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = AluOpSub;
        branch    = 1'b1;
        pc_src    = 2'b01;
        state_d   = StFetch;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StJump: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Reset presents the idle FETCH datapath setup with every strobe held low.
    if (rst) begin
      mem_req    = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b01;
      alu_op     = AluOpAdd;
      pc_src     = 2'b00;
      pc_write   = 1'b0;
      branch     = 1'b0;
      illegal_op = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  assign bus.mem_req    = mem_req;
  assign bus.IorD       = iord;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.RegDst     = reg_dst;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.RegWrite   = reg_write;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUcontrol = alu_control;
  assign bus.PCSrc      = pc_src;
  assign bus.PCEn       = pc_write | (branch & bus.zero);
  assign bus.illegal_op = illegal_op;
  assign bus.busy_state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: builds the expected per-cycle state trace
// of each instruction from its class and wait counts, then checks every cycle.
module tb_multicycle_control_fsm;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus_if ();

  multicycle_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int   exp_st[$];
  logic exp_rdy[$];

  logic [16:0] dut_ctrl;
  assign dut_ctrl = {bus_if.mem_req, bus_if.IorD, bus_if.MemWrite, bus_if.IRWrite,
                     bus_if.RegDst, bus_if.MemtoReg, bus_if.RegWrite, bus_if.ALUSrcA,
                     bus_if.ALUSrcB, bus_if.ALUcontrol, bus_if.PCSrc, bus_if.PCEn,
                     bus_if.illegal_op};

  // 0 lw, 1 sw, 2 R-type, 3 addi, 4 beq, 5 j, 6 illegal
  function automatic int instr_class(logic [5:0] op, logic [5:0] fn);
    if (op == 6'b100011) return 0;
    if (op == 6'b101011) return 1;
    if (op == 6'b001000) return 3;
    if (op == 6'b000100) return 4;
    if (op == 6'b000010) return 5;
    if (op == 6'b000000 && (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                            fn == 6'b100101 || fn == 6'b101010)) return 2;
    return 6;
  endfunction

  function automatic logic [2:0] funct_alu(logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [16:0] exp_ctrl(int st, logic rdy, logic z, logic [5:0] op,
                                           logic [5:0] fn);
    logic mreq = 0, iord = 0, mw = 0, irw = 0, rdst = 0, m2r = 0, rw = 0, asa = 0;
    logic [1:0] asb = 2'b00, pcs = 2'b00;
    logic [2:0] aluc = 3'b010;
    logic pce = 0, ill = 0;
    case (st)
      0:  begin mreq = 1; asb = 2'b01; irw = rdy; pce = rdy; end
      1:  begin asb = 2'b11; ill = (instr_class(op, fn) == 6); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mreq = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mreq = 1; iord = 1; mw = 1; end
      6:  begin asa = 1; aluc = funct_alu(fn); end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aluc = 3'b110; pcs = 2'b01; pce = z; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pce = 1; end
      default: ;
    endcase
    return {mreq, iord, mw, irw, rdst, m2r, rw, asa, asb, aluc, pcs, pce, ill};
  endfunction

  // Expected state trace: FETCH waits, then the class-specific path.
  function automatic void build_seq(logic [5:0] op, logic [5:0] fn, int wf, int wm);
    int c = instr_class(op, fn);
    exp_st.delete();
    exp_rdy.delete();
    for (int k = 0; k < wf; k++) begin exp_st.push_back(0); exp_rdy.push_back(1'b0); end
    exp_st.push_back(0); exp_rdy.push_back(1'b1);
    exp_st.push_back(1); exp_rdy.push_back(1'($urandom_range(0, 1)));
    case (c)
      0, 1: begin
        exp_st.push_back(2); exp_rdy.push_back(1'($urandom_range(0, 1)));
        for (int k = 0; k < wm; k++) begin
          exp_st.push_back(c == 0 ? 3 : 5); exp_rdy.push_back(1'b0);
        end
        exp_st.push_back(c == 0 ? 3 : 5); exp_rdy.push_back(1'b1);
        if (c == 0) begin exp_st.push_back(4); exp_rdy.push_back(1'($urandom_range(0, 1))); end
      end
      2: begin exp_st.push_back(6); exp_st.push_back(7); end
      3: begin exp_st.push_back(9); exp_st.push_back(10); end
      4: exp_st.push_back(8);
      5: exp_st.push_back(11);
      default: ;
    endcase
    while (exp_rdy.size() < exp_st.size()) exp_rdy.push_back(1'($urandom_range(0, 1)));
  endfunction

  task automatic drive(logic [5:0] op, logic [5:0] fn, int i, logic z);
    bus_if.opcode    = op;
    bus_if.funct     = fn;
    bus_if.mem_ready = exp_rdy[i];
    bus_if.zero      = (exp_st[i] == 8) ? z : 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    logic [16:0] rv = exp_ctrl(0, 1'b0, 1'b0, 6'd0, 6'd0) & ~17'h10000;
    rst = 1'b1;
    bus_if.opcode = 6'd0; bus_if.funct = 6'd0; bus_if.zero = 1'b0; bus_if.mem_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (bus_if.busy_state !== 4'd0) begin
        n_bad++; $display("FAIL reset_state got %0d want 0", bus_if.busy_state);
      end
      n_cmp++;
      if (dut_ctrl !== rv) begin
        n_bad++; $display("FAIL reset_ctrl got %h want %h", dut_ctrl, rv);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_lw();
    logic [5:0] op = 6'b100011, fn = 6'($urandom);
    int rw_cnt = 0;
    build_seq(op, fn, 0, 0);
    foreach (exp_st[i]) begin
      drive(op, fn, i, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (bus_if.busy_state !== 4'(exp_st[i])) begin
        n_bad++; $display("FAIL lw_state cyc%0d got %0d want %0d", i, bus_if.busy_state, exp_st[i]);
      end
      n_cmp++;
      if (dut_ctrl !== exp_ctrl(exp_st[i], exp_rdy[i], bus_if.zero, op, fn)) begin
        n_bad++; $display("FAIL lw_ctrl cyc%0d got %h want %h", i, dut_ctrl,
                          exp_ctrl(exp_st[i], exp_rdy[i], bus_if.zero, op, fn));
      end
      if (bus_if.RegWrite === 1'b1) rw_cnt++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (rw_cnt != 1) begin n_bad++; $display("FAIL lw_regwrite_cycles got %0d want 1", rw_cnt); end
  endtask

  task automatic test_sw_wait();
    logic [5:0] op = 6'b101011, fn = 6'($urandom);
    int mw_cnt = 0, rw_cnt = 0;
    build_seq(op, fn, $urandom_range(0, 2), 2);
    foreach (exp_st[i]) begin
      drive(op, fn, i, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (bus_if.busy_state !== 4'(exp_st[i])) begin
        n_bad++; $display("FAIL sw_state cyc%0d got %0d want %0d", i, bus_if.busy_state, exp_st[i]);
      end
      n_cmp++;
      if (dut_ctrl !== exp_ctrl(exp_st[i], exp_rdy[i], bus_if.zero, op, fn)) begin
        n_bad++; $display("FAIL sw_ctrl cyc%0d got %h want %h", i, dut_ctrl,
                          exp_ctrl(exp_st[i], exp_rdy[i], bus_if.zero, op, fn));
      end
      if (bus_if.MemWrite === 1'b1 && bus_if.mem_req === 1'b1 && bus_if.IorD === 1'b1) mw_cnt++;
      if (bus_if.RegWrite !== 1'b0) rw_cnt++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (mw_cnt != 3) begin n_bad++; $display("FAIL sw_memwrite_cycles got %0d want 3", mw_cnt); end
    n_cmp++;
    if (rw_cnt != 0) begin n_bad++; $display("FAIL sw_regwrite_cycles got %0d want 0", rw_cnt); end
  endtask

  task automatic test_rtype();
    logic [5:0] fns [2];
    logic [2:0] want [2];
    fns[0] = 6'b100010; want[0] = 3'b110;
    fns[1] = 6'b101010; want[1] = 3'b111;
    for (int t = 0; t < 2; t++) begin
      build_seq(6'b000000, fns[t], $urandom_range(0, 2), 0);
      foreach (exp_st[i]) begin
        drive(6'b000000, fns[t], i, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (bus_if.busy_state !== 4'(exp_st[i])) begin
          n_bad++; $display("FAIL rtype_state cyc%0d got %0d want %0d", i, bus_if.busy_state,
                            exp_st[i]);
        end
        n_cmp++;
        if (dut_ctrl !== exp_ctrl(exp_st[i], exp_rdy[i], bus_if.zero, 6'b000000, fns[t])) begin
          n_bad++; $display("FAIL rtype_ctrl cyc%0d got %h want %h", i, dut_ctrl,
                            exp_ctrl(exp_st[i], exp_rdy[i], bus_if.zero, 6'b000000, fns[t]));
        end
        if (exp_st[i] == 6) begin
          n_cmp++;
          if (bus_if.ALUcontrol !== want[t]) begin
            n_bad++; $display("FAIL rtype_aluctl got %b want %b", bus_if.ALUcontrol, want[t]);
          end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_beq();
    for (int t = 0; t < 2; t++) begin
      logic z = (t == 0);
      build_seq(6'b000100, 6'($urandom), 0, 0);
      foreach (exp_st[i]) begin
        drive(6'b000100, 6'd0, i, z);
        @(negedge clk);
        n_cmp++;
        if (bus_if.busy_state !== 4'(exp_st[i])) begin
          n_bad++; $display("FAIL beq_state cyc%0d got %0d want %0d", i, bus_if.busy_state,
                            exp_st[i]);
        end
        if (exp_st[i] == 8) begin
          n_cmp++;
          if (bus_if.PCEn !== z || bus_if.PCSrc !== 2'b01) begin
            n_bad++; $display("FAIL beq_pcen z=%0d got pcen=%b pcsrc=%b want pcen=%b pcsrc=01",
                              z, bus_if.PCEn, bus_if.PCSrc, z);
          end
        end
        @(posedge clk); #1;
      end
      @(negedge clk);
      n_cmp++;
      if (bus_if.busy_state !== 4'd0) begin
        n_bad++; $display("FAIL beq_return got %0d want 0", bus_if.busy_state);
      end
      @(posedge clk); #1;
      // The extra cycle above was spent in FETCH with random mem_ready.
      if (bus_if.busy_state === 4'd1) begin
        bus_if.opcode = 6'b000010;
        @(posedge clk); #1;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [3];
    logic [5:0] fns [3];
    ops[0] = 6'b011010; fns[0] = 6'b100000;
    ops[1] = 6'b000000; fns[1] = 6'b011100;
    ops[2] = 6'b000111; fns[2] = 6'b100000;
    for (int t = 0; t < 3; t++) begin
      int ill_cnt = 0, wr_cnt = 0;
      build_seq(ops[t], fns[t], $urandom_range(0, 2), 0);
      foreach (exp_st[i]) begin
        drive(ops[t], fns[t], i, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (bus_if.busy_state !== 4'(exp_st[i])) begin
          n_bad++; $display("FAIL illegal%0d_state cyc%0d got %0d want %0d", t, i,
                            bus_if.busy_state, exp_st[i]);
        end
        if (bus_if.illegal_op === 1'b1) ill_cnt++;
        if (bus_if.RegWrite !== 1'b0 || bus_if.MemWrite !== 1'b0) wr_cnt++;
        @(posedge clk); #1;
      end
      bus_if.mem_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (ill_cnt != 1 || bus_if.illegal_op !== 1'b0 || bus_if.busy_state !== 4'd0) begin
        n_bad++; $display("FAIL illegal%0d_pulse got cnt=%0d state=%0d want cnt=1 state=0",
                          t, ill_cnt, bus_if.busy_state);
      end
      n_cmp++;
      if (wr_cnt != 0) begin n_bad++; $display("FAIL illegal%0d_writes got %0d want 0", t, wr_cnt); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump();
    build_seq(6'b000010, 6'($urandom), 1, 0);
    foreach (exp_st[i]) begin
      drive(6'b000010, 6'd0, i, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (dut_ctrl !== exp_ctrl(exp_st[i], exp_rdy[i], bus_if.zero, 6'b000010, 6'd0) ||
          bus_if.busy_state !== 4'(exp_st[i])) begin
        n_bad++; $display("FAIL jump cyc%0d got st=%0d ctrl=%h want st=%0d ctrl=%h", i,
                          bus_if.busy_state, dut_ctrl, exp_st[i],
                          exp_ctrl(exp_st[i], exp_rdy[i], bus_if.zero, 6'b000010, 6'd0));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_access();
    logic [16:0] rv = exp_ctrl(0, 1'b0, 1'b0, 6'd0, 6'd0) & ~17'h10000;
    build_seq(6'b100011, 6'd0, 0, 6);
    for (int i = 0; i < 4; i++) begin
      drive(6'b100011, 6'd0, i, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (bus_if.busy_state !== 4'(exp_st[i])) begin
        n_bad++; $display("FAIL rstmid_state cyc%0d got %0d want %0d", i, bus_if.busy_state,
                          exp_st[i]);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    bus_if.mem_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_ctrl !== rv) begin
        n_bad++; $display("FAIL rstmid_ctrl cyc%0d got %h want %h", c, dut_ctrl, rv);
      end
      if (c == 1) begin
        n_cmp++;
        if (bus_if.busy_state !== 4'd0) begin
          n_bad++; $display("FAIL rstmid_state got %0d want 0", bus_if.busy_state);
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] legal_ops [6];
    logic [5:0] legal_fns [5];
    legal_ops[0] = 6'b100011; legal_ops[1] = 6'b101011; legal_ops[2] = 6'b000000;
    legal_ops[3] = 6'b001000; legal_ops[4] = 6'b000100; legal_ops[5] = 6'b000010;
    legal_fns[0] = 6'b100000; legal_fns[1] = 6'b100010; legal_fns[2] = 6'b100100;
    legal_fns[3] = 6'b100101; legal_fns[4] = 6'b101010;
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op, fn;
      logic z = 1'($urandom_range(0, 1));
      int sel = $urandom_range(0, 7);
      if (sel < 6) begin
        op = legal_ops[sel];
        fn = (op == 6'b000000) ? legal_fns[$urandom_range(0, 4)] : 6'($urandom);
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      build_seq(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
      foreach (exp_st[i]) begin
        drive(op, fn, i, z);
        @(negedge clk);
        n_cmp++;
        if (bus_if.busy_state !== 4'(exp_st[i])) begin
          n_bad++; $display("FAIL b2b%0d_state cyc%0d op=%b fn=%b got %0d want %0d", n, i, op,
                            fn, bus_if.busy_state, exp_st[i]);
        end
        n_cmp++;
        if (dut_ctrl !== exp_ctrl(exp_st[i], exp_rdy[i], bus_if.zero, op, fn)) begin
          n_bad++; $display("FAIL b2b%0d_ctrl cyc%0d op=%b fn=%b got %h want %h", n, i, op, fn,
                            dut_ctrl, exp_ctrl(exp_st[i], exp_rdy[i], bus_if.zero, op, fn));
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_rtype();
    test_beq();
    test_reset();
    test_illegal();
    test_jump();
    test_reset_mid_access();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
